// File: rtl/ecdsa_sign_ctrl.sv
// ECDSA signing sequencer: draws a nonce, obtains r from k*G, then computes
// s = k^-1 * (z + r*d) mod n using external point-multiplier, inverter and a
// shared mod-n multiplier. Rejected nonces are retried up to MAX_RETRY times.
module ecdsa_sign_ctrl #(
  parameter int WIDTH     = 256,
  parameter int MAX_RETRY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] priv_key,
  input  logic [WIDTH-1:0] n_order,
  output logic             done,
  output logic             fail,
  output logic [WIDTH-1:0] sig_r,
  output logic [WIDTH-1:0] sig_s,
  output logic [7:0]       retry_cnt,
  output logic             rng_req,
  input  logic             rng_ack,
  input  logic [WIDTH-1:0] rng_val,
  output logic [WIDTH-1:0] k_out,
  output logic             pm_req,
  input  logic             pm_ack,
  input  logic [WIDTH-1:0] pm_x,
  output logic             inv_req,
  input  logic             inv_ack,
  input  logic [WIDTH-1:0] inv_out,
  output logic             mm_req,
  input  logic             mm_ack,
  input  logic [WIDTH-1:0] mm_out,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b
);

  typedef enum logic [3:0] {
    IDLE, DRAW, POINT, RED_R, INV, MUL_RD, ADD_Z, MUL_S, CHK_S, FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] zr, d, px, r, kinv, t, s;

  logic             k_ok, retry;
  logic [WIDTH-1:0] r_red, u_red;
  logic [WIDTH:0]   sum;
  logic [7:0]       retry_nxt;

  // Single-step arithmetic and the rejection conditions of the current state.
  // u travels to the multiplier through mm_a, so it has no register of its own.
  always_comb begin
    k_ok      = (rng_val != '0) && (rng_val < n_order);
    r_red     = (px >= n_order) ? px - n_order : px;
    sum       = {1'b0, zr} + {1'b0, t};
    u_red     = (sum >= {1'b0, n_order}) ? WIDTH'(sum - {1'b0, n_order}) : sum[WIDTH-1:0];
    retry_nxt = retry_cnt + 8'd1;
    retry     = (state == DRAW  && rng_req && rng_ack && !k_ok) ||
                (state == RED_R && r_red == '0) ||
                (state == CHK_S && s == '0);
  end

  // Signing FSM; all outputs registered, retry handling overrides the state step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0; fail <= 1'b0; sig_r <= '0; sig_s <= '0; retry_cnt <= '0;
      rng_req <= 1'b0; pm_req <= 1'b0; inv_req <= 1'b0; mm_req <= 1'b0;
      k_out <= '0; mm_a <= '0; mm_b <= '0;
      zr <= '0; d <= '0; px <= '0; r <= '0; kinv <= '0; t <= '0; s <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          zr        <= (z >= n_order) ? z - n_order : z;
          d         <= priv_key;
          sig_r     <= '0;
          sig_s     <= '0;
          fail      <= 1'b0;
          retry_cnt <= '0;
          rng_req   <= 1'b1;
          state     <= DRAW;
        end
        DRAW: if (rng_req && rng_ack) begin
          rng_req <= 1'b0;
          if (k_ok) begin
            k_out  <= rng_val;
            pm_req <= 1'b1;
            state  <= POINT;
          end
        end
        POINT: if (pm_req && pm_ack) begin
          pm_req <= 1'b0;
          px     <= pm_x;
          state  <= RED_R;
        end
        RED_R: if (r_red != '0) begin
          r       <= r_red;
          inv_req <= 1'b1;
          state   <= INV;
        end
        INV: if (inv_req && inv_ack) begin
          inv_req <= 1'b0;
          kinv    <= inv_out;
          mm_req  <= 1'b1;
          mm_a    <= r;
          mm_b    <= d;
          state   <= MUL_RD;
        end
        MUL_RD: if (mm_req && mm_ack) begin
          mm_req <= 1'b0;
          t      <= mm_out;
          state  <= ADD_Z;
        end
        ADD_Z: begin
          mm_req <= 1'b1;
          mm_a   <= u_red;
          mm_b   <= kinv;
          state  <= MUL_S;
        end
        MUL_S: if (mm_req && mm_ack) begin
          mm_req <= 1'b0;
          s      <= mm_out;
          state  <= CHK_S;
        end
        CHK_S: if (s != '0) begin
          sig_r <= r;
          sig_s <= s;
          done  <= 1'b1;
          state <= FINISH;
        end
        FINISH: begin
          // scrub nonce-derived secrets before going idle
          k_out <= '0; kinv <= '0; t <= '0; mm_a <= '0; mm_b <= '0;
          px <= '0; s <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (retry) begin
        retry_cnt <= retry_nxt;
        if (retry_nxt == 8'(MAX_RETRY)) begin
          fail    <= 1'b1;
          done    <= 1'b1;
          sig_r   <= '0;
          sig_s   <= '0;
          rng_req <= 1'b0;
          state   <= FINISH;
        end else begin
          rng_req <= 1'b1;
          state   <= DRAW;
        end
      end
    end
  end

endmodule

// File: tb/tb_ecdsa_sign_ctrl.sv
// Bench for ecdsa_sign_ctrl: ideal nonce/point/inverter/multiplier units with
// random latency, directed cases plus random signing runs checked against a
// plain-arithmetic ECDSA model.
module tb_ecdsa_sign_ctrl;
  localparam int W = 8;
  localparam int N = 251;
  localparam int MAXR = 3;

  logic clk, reset, start;
  logic [W-1:0] z, priv_key, n_order;
  logic done, fail;
  logic [W-1:0] sig_r, sig_s;
  logic [7:0] retry_cnt;
  logic rng_req, rng_ack, pm_req, pm_ack, inv_req, inv_ack, mm_req, mm_ack;
  logic [W-1:0] rng_val, k_out, pm_x, inv_out, mm_out, mm_a, mm_b;

  int vectors = 0, miscompares = 0;
  int rng_list[$], pm_list[$], rng_q[$], pm_q[$];
  int lat_rng = 0, lat_pm = 0, lat_inv = 0, lat_mm = 0;
  int c_rng = 0, c_pm = 0, c_inv = 0, c_mm = 0;
  bit auto_inv = 1;

  ecdsa_sign_ctrl #(.WIDTH(W), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .z(z), .priv_key(priv_key),
    .n_order(n_order), .done(done), .fail(fail), .sig_r(sig_r), .sig_s(sig_s),
    .retry_cnt(retry_cnt), .rng_req(rng_req), .rng_ack(rng_ack), .rng_val(rng_val),
    .k_out(k_out), .pm_req(pm_req), .pm_ack(pm_ack), .pm_x(pm_x),
    .inv_req(inv_req), .inv_ack(inv_ack), .inv_out(inv_out),
    .mm_req(mm_req), .mm_ack(mm_ack), .mm_out(mm_out), .mm_a(mm_a), .mm_b(mm_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modinv(int a, int n);
    for (int x = 1; x < n; x++) if ((a * x) % n == 1) return x;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ECDSA signing outcome from the nonce and k*G streams, in plain integers
  task automatic model(input int zz, input int dd, output int ef, output int er,
                       output int es, output int ec);
    int zp, k, px, rr, ss, ri, pi;
    zp = (zz >= N) ? zz - N : zz;
    ec = 0; ri = 0; pi = 0;
    for (int a = 0; a < MAXR; a++) begin
      k = rng_list[ri]; ri++;
      if (k < 1 || k >= N) begin ec++; continue; end
      px = pm_list[pi]; pi++;
      rr = px % N;
      if (rr == 0) begin ec++; continue; end
      ss = (((zp + rr * dd) % N) * modinv(k, N)) % N;
      if (ss == 0) begin ec++; continue; end
      ef = 0; er = rr; es = ss;
      return;
    end
    ef = 1; er = 0; es = 0;
  endtask

  // ideal external units, acting on the falling edge
  initial forever begin
    @(negedge clk);
    if (rng_ack) rng_ack = 1'b0;
    else if (rng_req) begin
      if (c_rng >= lat_rng) begin
        rng_val = (rng_q.size() > 0) ? W'(rng_q.pop_front()) : '0;
        rng_ack = 1'b1; c_rng = 0;
      end else c_rng++;
    end else c_rng = 0;
  end
  initial forever begin
    @(negedge clk);
    if (pm_ack) pm_ack = 1'b0;
    else if (pm_req) begin
      if (c_pm >= lat_pm) begin
        pm_x = (pm_q.size() > 0) ? W'(pm_q.pop_front()) : '0;
        pm_ack = 1'b1; c_pm = 0;
      end else c_pm++;
    end else c_pm = 0;
  end
  initial forever begin
    @(negedge clk);
    if (auto_inv) begin
      if (inv_ack) inv_ack = 1'b0;
      else if (inv_req) begin
        if (c_inv >= lat_inv) begin
          inv_out = W'(modinv(int'(k_out), N));
          inv_ack = 1'b1; c_inv = 0;
        end else c_inv++;
      end else c_inv = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (mm_ack) mm_ack = 1'b0;
    else if (mm_req) begin
      if (c_mm >= lat_mm) begin
        mm_out = W'((int'(mm_a) * int'(mm_b)) % N);
        mm_ack = 1'b1; c_mm = 0;
      end else c_mm++;
    end else c_mm = 0;
  end

  // one signing run; a stray start is thrown in mid-operation
  task automatic run_op(input int zz, input int dd, output bit seen, output int of,
                        output int orr, output int os, output int oc);
    rng_q = rng_list; pm_q = pm_list;
    z = W'(zz); priv_key = W'(dd); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rng_req_after_start", rng_req, 1);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (i == 2) begin z = 8'hA5; priv_key = 8'h3C; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      if (done) begin
        seen = 1; of = fail; orr = sig_r; os = sig_s; oc = retry_cnt;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("k_out_zeroized", k_out, 0);
  endtask

  task automatic check_op(string tag, input int zz, input int dd,
                          input int ef, input int er, input int es, input int ec);
    bit seen; int of, orr, os, oc;
    run_op(zz, dd, seen, of, orr, os, oc);
    chk({tag, "_fail"}, of, ef);
    chk({tag, "_sig_r"}, orr, er);
    chk({tag, "_sig_s"}, os, es);
    chk({tag, "_retry"}, oc, ec);
  endtask

  initial begin
    bit seen_done;
    int ef, er, es, ec;
    reset = 1'b1; start = 1'b0; z = '0; priv_key = '0; n_order = W'(N);
    rng_ack = 0; pm_ack = 0; inv_ack = 0; mm_ack = 0;
    rng_val = '0; pm_x = '0; inv_out = '0; mm_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_sig_r", sig_r, 0);
    chk("rst_sig_s", sig_s, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_reqs", {rng_req, pm_req, inv_req, mm_req}, 0);
    chk("rst_k_out", k_out, 0);
    reset = 1'b0;
    @(negedge clk);

    rng_list = '{3}; pm_list = '{5};
    check_op("basic", 16, 7, 0, 5, 17, 0);
    lat_rng = 2; lat_pm = 1; lat_inv = 3; lat_mm = 1;
    rng_list = '{0, 3}; pm_list = '{5};
    check_op("bad_k", 16, 7, 0, 5, 17, 1);
    rng_list = '{3, 3}; pm_list = '{251, 5};
    check_op("r_zero", 16, 7, 0, 5, 17, 1);
    rng_list = '{0, 0, 0}; pm_list = '{5};
    check_op("exhaust", 16, 7, 1, 0, 0, 3);
    repeat (4) @(negedge clk);
    chk("fail_held", fail, 1);
    lat_rng = 0; lat_pm = 0; lat_inv = 0; lat_mm = 0;
    rng_list = '{3}; pm_list = '{5};
    check_op("z_reduce", 255, 7, 0, 5, 13, 0);

    // reset while inv_req is up, ack arriving after reset
    auto_inv = 0;
    rng_q = '{3}; pm_q = '{5};
    z = 8'h10; priv_key = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      @(negedge clk);
      if (inv_req) seen_done = 1;
    end
    chk("inv_req_seen", seen_done, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; inv_ack = 1'b1; inv_out = 8'd84;
    @(negedge clk);
    inv_ack = 1'b0;
    chk("rst_mid_reqs", {rng_req, pm_req, inv_req, mm_req}, 0);
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || rng_req || pm_req || inv_req || mm_req) seen_done = 1;
    end
    chk("rst_mid_quiet", seen_done, 0);
    chk("rst_mid_k_out", k_out, 0);
    auto_inv = 1;
    rng_list = '{3}; pm_list = '{5};
    check_op("recover", 16, 7, 0, 5, 17, 0);

    // random signing runs against the model
    for (int it = 0; it < 25; it++) begin
      int zz, dd;
      zz = $urandom_range(0, 255); dd = $urandom_range(1, 250);
      lat_rng = $urandom_range(0, 3); lat_pm = $urandom_range(0, 3);
      lat_inv = $urandom_range(0, 3); lat_mm = $urandom_range(0, 3);
      rng_list = {}; pm_list = {};
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 9) < 7) rng_list.push_back($urandom_range(1, 250));
        else rng_list.push_back(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(251, 255)));
        if ($urandom_range(0, 9) < 8) pm_list.push_back($urandom_range(0, 255));
        else pm_list.push_back(($urandom_range(0, 1) == 0) ? 0 : 251);
      end
      model(zz, dd, ef, er, es, ec);
      check_op("rand", zz, dd, ef, er, es, ec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
